// File: rtl/rggen_address_decoder_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : rggen_address_decoder_array_if
//  Description : Bundle of the signals between the host-bus adapter, the
//                address decoder array and the register instances.
//                The host/register side uses the master modport. The
//                decoder uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rggen_address_decoder_array_if #(
    parameter int REGISTERS          = 4,
    parameter int ADDRESS_WIDTH      = 16,
    parameter int SHADOW_INDEX_WIDTH = 1
);
    logic                          i_request_valid;
    logic                          o_request_ready;
    logic                          i_write;
    logic [ADDRESS_WIDTH-1:0]      i_address;
    logic [SHADOW_INDEX_WIDTH-1:0] i_shadow_index;
    logic [REGISTERS-1:0]          o_select;
    logic                          o_write;
    logic                          i_access_done;
    logic                          o_response_valid;
    logic [1:0]                    o_response_status;
    logic                          i_response_ready;

    // Host adapter and register instances.
    modport master (
        output i_request_valid,
        output i_write,
        output i_address,
        output i_shadow_index,
        output i_access_done,
        output i_response_ready,
        input  o_request_ready,
        input  o_select,
        input  o_write,
        input  o_response_valid,
        input  o_response_status
    );

    // Decoder side.
    modport slave (
        input  i_request_valid,
        input  i_write,
        input  i_address,
        input  i_shadow_index,
        input  i_access_done,
        input  i_response_ready,
        output o_request_ready,
        output o_select,
        output o_write,
        output o_response_valid,
        output o_response_status
    );
endinterface
`default_nettype wire

// File: rtl/rggen_address_decoder_array.sv
`default_nettype none
// ============================================================================
//  Module      : rggen_address_decoder_array
//  Description : Registered multi-register address decoder and access
//                sequencer. It captures one host request and decodes it
//                against REGISTERS address ranges, with an optional shadow
//                index. It then drives a one-hot select until the register
//                completes, and returns a 2-bit status response.
//                Status values: 00 OKAY, 01 ACCESS_ERROR, 10 DECODE_ERROR,
//                11 TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module rggen_address_decoder_array #(
    parameter int                                       REGISTERS           = 4,
    parameter int                                       ADDRESS_WIDTH       = 16,
    parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]       START_ADDRESSES     = '0,
    parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]       END_ADDRESSES       = '0,
    parameter logic [REGISTERS-1:0]                     READABLE            = '1,
    parameter logic [REGISTERS-1:0]                     WRITABLE            = '1,
    parameter logic [REGISTERS-1:0]                     USE_SHADOW_INDEX    = '0,
    parameter int                                       SHADOW_INDEX_WIDTH  = 1,
    parameter logic [REGISTERS*SHADOW_INDEX_WIDTH-1:0]  SHADOW_INDEX_VALUES = '0,
    parameter int                                       TIMEOUT_CYCLES      = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    rggen_address_decoder_array_if.slave    bus
);

    // Watchdog counter width. A zero timeout still needs a 1-bit counter.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] c_STATUS_OKAY         = 2'b00;
    localparam logic [1:0] c_STATUS_ACCESS_ERROR = 2'b01;
    localparam logic [1:0] c_STATUS_DECODE_ERROR = 2'b10;
    localparam logic [1:0] c_STATUS_TIMEOUT      = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        ACCESS   = 2'd2,
        RESPONSE = 2'd3
    } state_t;

    state_t                         r_state;
    logic                           r_request_ready;
    logic                           r_req_write;
    logic [ADDRESS_WIDTH-1:0]       r_req_address;
    logic [SHADOW_INDEX_WIDTH-1:0]  r_req_shadow_index;
    logic [REGISTERS-1:0]           r_select;
    logic                           r_write;
    logic                           r_response_valid;
    logic [1:0]                     r_response_status;
    logic [c_CNT_W-1:0]             r_count;

    logic [REGISTERS-1:0]           w_match;
    logic [REGISTERS-1:0]           w_onehot;
    logic                           w_hit;
    logic                           w_readable;
    logic                           w_writable;
    logic                           w_allowed;
    logic                           w_timeout;

    // Per-register range and shadow-index match on the captured request.
    generate
        for (genvar g = 0; g < REGISTERS; g++) begin : g_match
            localparam logic [ADDRESS_WIDTH-1:0] c_START =
                START_ADDRESSES[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            localparam logic [ADDRESS_WIDTH-1:0] c_END =
                END_ADDRESSES[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            localparam logic [SHADOW_INDEX_WIDTH-1:0] c_SHADOW =
                SHADOW_INDEX_VALUES[g*SHADOW_INDEX_WIDTH +: SHADOW_INDEX_WIDTH];

            logic w_in_range;
            logic w_shadow_ok;

            assign w_in_range  = (r_req_address >= c_START) && (r_req_address <= c_END);
            assign w_shadow_ok = !USE_SHADOW_INDEX[g] || (r_req_shadow_index == c_SHADOW);
            assign w_match[g]  = w_in_range && w_shadow_ok;
        end
    endgenerate

    // Priority pick: scan from the top so the lowest matching index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_onehot   = '0;
        w_readable = 1'b0;
        w_writable = 1'b0;
        for (int i = REGISTERS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit       = 1'b1;
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_readable  = READABLE[i];
                w_writable  = WRITABLE[i];
            end
        end
    end

    assign w_allowed = r_req_write ? w_writable : w_readable;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_count == c_TIMEOUT_LAST);

    // Request/decode/access/response sequencer; every output is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_request_ready    <= 1'b0;
            r_req_write        <= 1'b0;
            r_req_address      <= '0;
            r_req_shadow_index <= '0;
            r_select           <= '0;
            r_write            <= 1'b0;
            r_response_valid   <= 1'b0;
            r_response_status  <= c_STATUS_OKAY;
            r_count            <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_request_valid && r_request_ready) begin
                        r_req_write        <= bus.i_write;
                        r_req_address      <= bus.i_address;
                        r_req_shadow_index <= bus.i_shadow_index;
                        r_request_ready    <= 1'b0;
                        r_state            <= DECODE;
                    end else begin
                        r_request_ready    <= 1'b1;
                    end
                end

                DECODE: begin
                    r_count <= '0;
                    if (!w_hit) begin
                        r_response_valid  <= 1'b1;
                        r_response_status <= c_STATUS_DECODE_ERROR;
                        r_state           <= RESPONSE;
                    end else if (!w_allowed) begin
                        r_response_valid  <= 1'b1;
                        r_response_status <= c_STATUS_ACCESS_ERROR;
                        r_state           <= RESPONSE;
                    end else begin
                        r_select <= w_onehot;
                        r_write  <= r_req_write;
                        r_state  <= ACCESS;
                    end
                end

                ACCESS: begin
                    // Completion takes precedence over an expiring watchdog.
                    if (bus.i_access_done) begin
                        r_select          <= '0;
                        r_write           <= 1'b0;
                        r_response_valid  <= 1'b1;
                        r_response_status <= c_STATUS_OKAY;
                        r_state           <= RESPONSE;
                    end else if (w_timeout) begin
                        r_select          <= '0;
                        r_write           <= 1'b0;
                        r_response_valid  <= 1'b1;
                        r_response_status <= c_STATUS_TIMEOUT;
                        r_state           <= RESPONSE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                RESPONSE: begin
                    if (bus.i_response_ready) begin
                        r_response_valid <= 1'b0;
                        r_request_ready  <= 1'b1;
                        r_count          <= '0;
                        r_state          <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_request_ready   = r_request_ready;
    assign bus.o_select          = r_select;
    assign bus.o_write           = r_write;
    assign bus.o_response_valid  = r_response_valid;
    assign bus.o_response_status = r_response_status;

endmodule
`default_nettype wire

// File: tb/tb_rggen_address_decoder_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rggen_address_decoder_array
//  Description : Directed self-checking bench for the address decoder array.
//                Instance A holds four ranges. Instance B has two shadowed
//                registers at the same address. Instance C has two
//                unshadowed registers at the same address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rggen_address_decoder_array;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    rggen_address_decoder_array_if #(.REGISTERS(4), .ADDRESS_WIDTH(16), .SHADOW_INDEX_WIDTH(1)) if_a ();
    rggen_address_decoder_array_if #(.REGISTERS(2), .ADDRESS_WIDTH(16), .SHADOW_INDEX_WIDTH(1)) if_b ();
    rggen_address_decoder_array_if #(.REGISTERS(2), .ADDRESS_WIDTH(16), .SHADOW_INDEX_WIDTH(1)) if_c ();

    rggen_address_decoder_array #(
        .REGISTERS          (4),
        .ADDRESS_WIDTH      (16),
        .START_ADDRESSES    ({16'h0010, 16'h0008, 16'h0004, 16'h0000}),
        .END_ADDRESSES      ({16'h0010, 16'h000F, 16'h0004, 16'h0000}),
        .READABLE           (4'b1111),
        .WRITABLE           (4'b1101),
        .USE_SHADOW_INDEX   (4'b0000),
        .SHADOW_INDEX_WIDTH (1),
        .SHADOW_INDEX_VALUES(4'b0000),
        .TIMEOUT_CYCLES     (16)
    ) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_a.slave)
    );

    rggen_address_decoder_array #(
        .REGISTERS          (2),
        .ADDRESS_WIDTH      (16),
        .START_ADDRESSES    ({16'h0000, 16'h0000}),
        .END_ADDRESSES      ({16'h0000, 16'h0000}),
        .USE_SHADOW_INDEX   (2'b11),
        .SHADOW_INDEX_WIDTH (1),
        .SHADOW_INDEX_VALUES(2'b10),
        .TIMEOUT_CYCLES     (16)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_b.slave)
    );

    rggen_address_decoder_array #(
        .REGISTERS          (2),
        .ADDRESS_WIDTH      (16),
        .START_ADDRESSES    ({16'h0000, 16'h0000}),
        .END_ADDRESSES      ({16'h0000, 16'h0000}),
        .USE_SHADOW_INDEX   (2'b00),
        .SHADOW_INDEX_WIDTH (1),
        .SHADOW_INDEX_VALUES(2'b10),
        .TIMEOUT_CYCLES     (16)
    ) u_dut_c (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance A and return after the decode edge.
    task automatic send_a(input logic wr, input logic [15:0] addr);
        if_a.i_request_valid = 1'b1;
        if_a.i_write         = wr;
        if_a.i_address       = addr;
        if_a.i_shadow_index  = 1'b0;
        tick();
        if_a.i_request_valid = 1'b0;
        check_value("a_ready_after_accept", if_a.o_request_ready, 1'b0);
        tick();
    endtask

    // Check the pending response on instance A, then complete the handshake.
    task automatic finish_a(input string tag, input logic [1:0] status);
        check_value({tag, "_valid"},  if_a.o_response_valid,  1'b1);
        check_value({tag, "_status"}, if_a.o_response_status, status);
        check_value({tag, "_sel_off"}, if_a.o_select, 4'b0000);
        if_a.i_response_ready = 1'b1;
        tick();
        if_a.i_response_ready = 1'b0;
        check_value({tag, "_valid_drop"}, if_a.o_response_valid, 1'b0);
        tick();
        check_value({tag, "_ready_back"}, if_a.o_request_ready, 1'b1);
    endtask

    // Same request to instances B and C; check both selects, then complete.
    task automatic run_bc(input logic shadow, input logic [1:0] exp_b, input logic [1:0] exp_c);
        if_b.i_request_valid = 1'b1; if_b.i_write = 1'b0; if_b.i_address = 16'h0000; if_b.i_shadow_index = shadow;
        if_c.i_request_valid = 1'b1; if_c.i_write = 1'b0; if_c.i_address = 16'h0000; if_c.i_shadow_index = shadow;
        tick();
        if_b.i_request_valid = 1'b0;
        if_c.i_request_valid = 1'b0;
        tick();
        check_value("b_select", if_b.o_select, exp_b);
        check_value("c_select", if_c.o_select, exp_c);
        if_b.i_access_done = 1'b1;
        if_c.i_access_done = 1'b1;
        tick();
        if_b.i_access_done = 1'b0;
        if_c.i_access_done = 1'b0;
        check_value("b_status", {if_b.o_response_valid, if_b.o_response_status}, 3'b100);
        check_value("c_status", {if_c.o_response_valid, if_c.o_response_status}, 3'b100);
        if_b.i_response_ready = 1'b1;
        if_c.i_response_ready = 1'b1;
        tick();
        if_b.i_response_ready = 1'b0;
        if_c.i_response_ready = 1'b0;
        tick();
    endtask

    // Time limit so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        logic [2:0] held;

        if_a.i_request_valid = 0; if_a.i_write = 0; if_a.i_address = '0; if_a.i_shadow_index = '0;
        if_a.i_access_done = 0;   if_a.i_response_ready = 0;
        if_b.i_request_valid = 0; if_b.i_write = 0; if_b.i_address = '0; if_b.i_shadow_index = '0;
        if_b.i_access_done = 0;   if_b.i_response_ready = 0;
        if_c.i_request_valid = 0; if_c.i_write = 0; if_c.i_address = '0; if_c.i_shadow_index = '0;
        if_c.i_access_done = 0;   if_c.i_response_ready = 0;

        rst_n = 1'b0;
        tick();
        tick();
        check_value("rst_ready",  if_a.o_request_ready,   1'b0);
        check_value("rst_select", if_a.o_select,          4'b0000);
        check_value("rst_write",  if_a.o_write,           1'b0);
        check_value("rst_valid",  if_a.o_response_valid,  1'b0);
        check_value("rst_status", if_a.o_response_status, 2'b00);
        rst_n = 1'b1;
        tick();
        check_value("ready_after_reset", if_a.o_request_ready, 1'b1);

        // Read 0x0A hits register 2; done in the third access cycle.
        send_a(1'b0, 16'h000A);
        for (int k = 1; k <= 3; k++) begin
            check_value("rd_select", if_a.o_select, 4'b0100);
            check_value("rd_write",  if_a.o_write,  1'b0);
            if (k == 3) if_a.i_access_done = 1'b1;
            tick();
        end
        if_a.i_access_done = 1'b0;
        finish_a("rd", 2'b00);

        // Write 0x0C also hits register 2 and drives the write direction.
        send_a(1'b1, 16'h000C);
        check_value("wr_select", if_a.o_select, 4'b0100);
        check_value("wr_write",  if_a.o_write,  1'b1);
        if_a.i_access_done = 1'b1;
        tick();
        if_a.i_access_done = 1'b0;
        finish_a("wr", 2'b00);

        // Miss: the error response is already valid after the decode edge.
        send_a(1'b0, 16'h0020);
        finish_a("miss", 2'b10);

        // Write to read-only register 1: no select, access error.
        send_a(1'b1, 16'h0004);
        finish_a("viol", 2'b01);

        // Read of register 1 is permitted.
        send_a(1'b0, 16'h0004);
        check_value("rd1_select", if_a.o_select, 4'b0010);
        if_a.i_access_done = 1'b1;
        tick();
        if_a.i_access_done = 1'b0;
        finish_a("rd1", 2'b00);

        // Watchdog: select is held for exactly 16 cycles.
        send_a(1'b0, 16'h0000);
        cnt = 0;
        while (if_a.o_select != 4'b0000 && cnt < 40) begin
            cnt++;
            tick();
        end
        check_value("to_select_cycles", cnt, 16);
        check_value("to_status", {if_a.o_response_valid, if_a.o_response_status}, 3'b111);

        // Backpressure: response stays put and no request is accepted.
        if_a.i_request_valid = 1'b1;
        if_a.i_address       = 16'h0008;
        for (int k = 0; k < 5; k++) begin
            tick();
            held = {if_a.o_response_valid, if_a.o_response_status};
            check_value("bp_resp_hold", held, 3'b111);
            check_value("bp_no_accept", if_a.o_request_ready, 1'b0);
        end
        if_a.i_request_valid = 1'b0;
        finish_a("bp", 2'b11);

        // Done arriving in the last watchdog cycle wins.
        send_a(1'b0, 16'h0000);
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) if_a.i_access_done = 1'b1;
            tick();
        end
        if_a.i_access_done = 1'b0;
        finish_a("race", 2'b00);

        // Reset while register 0 is selected: everything drops, no response.
        send_a(1'b0, 16'h0000);
        check_value("mid_select", if_a.o_select, 4'b0001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_value("mid_rst_select", if_a.o_select,         4'b0000);
        check_value("mid_rst_valid",  if_a.o_response_valid, 1'b0);
        check_value("mid_rst_ready",  if_a.o_request_ready,  1'b0);
        tick();
        tick();
        check_value("mid_rst_no_resp", if_a.o_response_valid, 1'b0);
        check_value("mid_rst_idle",    if_a.o_request_ready,  1'b1);

        // Shadow-qualified and plain overlap.
        run_bc(1'b1, 2'b10, 2'b01);
        run_bc(1'b0, 2'b01, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rggen_address_decoder_array.md
Name: rggen_address_decoder_array

Overview:
- Registered, multi-register address decode and access sequencer, between the host-bus adapter and a register block's register instances.
- Decodes one request against REGISTERS address ranges, with per-register access type and optional shadow index.
- Holds a one-hot select until the selected register finishes, then returns a status response.
- Adds what single-entry combinational decoding lacks: request/response handshakes, miss/access-violation errors, and a watchdog timeout.

Parameters:
REGISTERS, 4, number of decoded registers (1..64)
ADDRESS_WIDTH, 16, host address width
START_ADDRESSES, 0, packed REGISTERS x ADDRESS_WIDTH range starts; entry i at bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
END_ADDRESSES, 0, packed range ends, inclusive; END >= START per entry
READABLE, all ones, REGISTERS-bit vector; bit i set = register i readable
WRITABLE, all ones, REGISTERS-bit vector; bit i set = register i writable
USE_SHADOW_INDEX, 0, REGISTERS-bit vector; bit i set = shadow index compared for register i
SHADOW_INDEX_WIDTH, 1, shadow index width
SHADOW_INDEX_VALUES, 0, packed REGISTERS x SHADOW_INDEX_WIDTH match values
TIMEOUT_CYCLES, 16, ACCESS-state cycles before timeout; 0 disables the watchdog

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
i_request_valid  input  1  host request valid
o_request_ready  output  1  request accepted when valid && ready
i_write  input  1  1 = write, 0 = read
i_address  input  ADDRESS_WIDTH  request address
i_shadow_index  input  SHADOW_INDEX_WIDTH  request shadow index
o_select  output  REGISTERS  one-hot register select
o_write  output  1  registered access direction for the selected register
i_access_done  input  1  selected register completed the access
o_response_valid  output  1  response valid
o_response_status  output  2  00 OKAY, 01 ACCESS_ERROR, 10 DECODE_ERROR, 11 TIMEOUT
i_response_ready  input  1  host accepts response

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset (rst_n low at a clk edge) forces:
  - state = IDLE, o_request_ready = 0, o_select = 0, o_write = 0
  - o_response_valid = 0, o_response_status = 00, timeout counter = 0
  - Applies mid-transaction too: select and response drop at that edge with no response issued.
- FSM states: IDLE, DECODE, ACCESS, RESPONSE.
- IDLE:
  - o_request_ready = 1 (registered; asserted the cycle after reset release).
  - On valid && ready: capture i_write, i_address, i_shadow_index; go to DECODE; ready deasserts.
- DECODE (exactly 1 cycle), on captured values:
  - match[i] = (START[i] <= addr <= END[i]) && (!USE_SHADOW_INDEX[i] || shadow == SHADOW_INDEX_VALUES[i]).
  - Overlapping matches: lowest index wins; the winner alone is used.
  - No match -> RESPONSE, status 10.
  - Winner not permitted (write to !WRITABLE, or read to !READABLE) -> RESPONSE, status 01; o_select never asserts.
  - Otherwise -> ACCESS; o_select = onehot(winner) and o_write = captured write, both from the next cycle.
- ACCESS:
  - o_select held stable; counter increments every cycle.
  - i_access_done = 1 -> RESPONSE, status 00; o_select clears at the same edge.
  - Counter reaching TIMEOUT_CYCLES-1 without done (TIMEOUT_CYCLES != 0) -> RESPONSE, status 11; select clears.
  - done in the same cycle as the timeout: done wins (status 00).
  - i_access_done outside ACCESS is ignored.
- RESPONSE:
  - o_response_valid = 1, status stable until i_response_ready.
  - On handshake -> IDLE; valid drops; ready returns next cycle.
  - No new request accepted before the response handshake.
- Latency:
  - Request accept to o_select: 2 clk edges.
  - Request accept to error response: 2 edges.
  - i_access_done to o_response_valid: 1 edge.
- Width rules:
  - Timeout counter width = clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Address compares are unsigned at ADDRESS_WIDTH.

Test Plan:
- Single read: REGISTERS=4, ranges 0x00,0x04,0x08-0x0F,0x10; read 0x0A, done after 3 cycles -> o_select=4'b0100 for 3 cycles, o_write=0, then status 00.
- Miss: read 0x20 -> o_select stays 0, o_response_valid 2 cycles after accept, status 10.
- Access violation: WRITABLE[1]=0, write 0x04 -> no select, status 01. Same setup, read 0x04 -> select 4'b0010, status 00.
- Shadow/overlap:
  - Registers 0 and 1 both at 0x00, USE_SHADOW_INDEX=2'b11, values 0/1; shadow=1 -> select 2'b10.
  - Both at 0x00 without shadow -> select 2'b01.
- Timeout and backpressure:
  - TIMEOUT_CYCLES=16, no done -> select high exactly 16 cycles, then status 11.
  - Hold i_response_ready=0 for 5 cycles -> valid and status stable, no request accepted.
  - done coincident with the last timeout cycle -> status 00.
- Reset mid-ACCESS: rst_n low for 1 cycle while select=4'b0001 -> next edge all outputs 0, state IDLE, no response issued.
